// File: rtl/laplacian_3x3.sv
`timescale 1ns/1ps
// laplacian_3x3
// Streaming 3x3 Laplacian edge filter for 8-bit grayscale frames in raster
// order. One |N+S+W+E-4C| byte (saturated to 255) is emitted per input
// pixel, tagged with the centre coordinate it belongs to. Two image rows are
// held in a single W x 16 line memory. After the last pixel of a frame, the
// remaining W+1 centres are flushed on their own.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active low
//   gray_valid     in   input pixel strobe (gaps allowed)
//   gray[7:0]      in   input pixel
//   lap_valid      out  one-cycle result strobe
//   lap_out[7:0]   out  filtered pixel
//   center_row_s1  out  centre row of lap_out
//   center_col_s1  out  centre column of lap_out
//
// Flush sequencer
//   state     | meaning
//   ST_RUN    | accepting pixels, results produced from the pixel stream
//   ST_FLUSH  | input ignored, one border result per cycle, flush_cnt counts down to 0

module laplacian_3x3 #(
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gray_valid,
   input  logic [7:0]  gray,
   output logic        lap_valid,
   output logic [7:0]  lap_out,
   output logic [31:0] center_row_s1,
   output logic [31:0] center_col_s1
);

   localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
   localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int FW = $clog2(IMAGE_WIDTH + 1);

   localparam logic [CW-1:0] COL_LAST   = CW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(IMAGE_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_ONE    = RW'(1);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(IMAGE_WIDTH);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t          state_q, state_d;
   logic [FW-1:0]   flush_cnt_q, flush_cnt_d;

   logic [RW-1:0]   in_row_q, in_row_d;
   logic [CW-1:0]   in_col_q, in_col_d;
   logic [RW-1:0]   out_row_q, out_row_d;
   logic [CW-1:0]   out_col_q, out_col_d;

   // stage 1: pixel captured, line memory read in flight
   logic            s1_valid_q, s1_valid_d;
   logic            s1_fetch_q, s1_fetch_d;
   logic [7:0]      s1_pix_q, s1_pix_d;
   logic [CW-1:0]   s1_addr_q, s1_addr_d;
   logic            s1_border_q, s1_border_d;
   logic [RW-1:0]   s1_row_q, s1_row_d;
   logic [CW-1:0]   s1_col_q, s1_col_d;

   // stage 2: 3-column window, col0 newest
   logic [7:0]      col0_t_q, col0_t_d, col0_m_q, col0_m_d, col0_b_q, col0_b_d;
   logic [7:0]      col1_t_q, col1_t_d, col1_m_q, col1_m_d, col1_b_q, col1_b_d;
   logic [7:0]      col2_m_q, col2_m_d;
   logic            s2_valid_q, s2_valid_d;
   logic            s2_border_q, s2_border_d;
   logic [RW-1:0]   s2_row_q, s2_row_d;
   logic [CW-1:0]   s2_col_q, s2_col_d;

   // output registers
   logic            lap_valid_q, lap_valid_d;
   logic [7:0]      lap_out_q, lap_out_d;
   logic [RW-1:0]   lap_row_q, lap_row_d;
   logic [CW-1:0]   lap_col_q, lap_col_d;

   // line memory entry: [15:8] = row r-2, [7:0] = row r-1 relative to incoming row r
   logic [15:0]     line_mem [IMAGE_WIDTH];
   logic [15:0]     mem_rd_q;

   logic            accept;
   logic            last_px;
   logic            primed;
   logic            produce;
   logic            out_border;
   logic signed [10:0] sum;
   logic [10:0]     mag;
   logic [7:0]      sat;

   // ---------------------------------------------------------------------
   // input side, flush sequencer, output-coordinate counter
   // ---------------------------------------------------------------------
   always_comb begin
      accept  = gray_valid && (state_q == ST_RUN);
      last_px = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
      // first result comes with pixel index W+1, i.e. (1,1)
      primed  = (in_row_q > ROW_ONE) || ((in_row_q == ROW_ONE) && (in_col_q != '0));
      produce = (accept && primed) || (state_q == ST_FLUSH);
      out_border = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
                   (out_col_q == '0) || (out_col_q == COL_LAST);
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (accept && last_px) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      in_row_d = in_row_q;
      in_col_d = in_col_q;
      if (accept) begin
         if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
         end else begin
            in_col_d = in_col_q + 1'b1;
         end
      end
   end

   always_comb begin
      out_row_d = out_row_q;
      out_col_d = out_col_q;
      if (produce) begin
         if (out_col_q == COL_LAST) begin
            out_col_d = '0;
            out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
         end else begin
            out_col_d = out_col_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // stage 1
   // ---------------------------------------------------------------------
   always_comb begin
      s1_valid_d  = produce;
      s1_fetch_d  = accept;
      s1_pix_d    = accept ? gray : s1_pix_q;
      s1_addr_d   = accept ? in_col_q : s1_addr_q;
      s1_border_d = produce ? out_border : s1_border_q;
      s1_row_d    = produce ? out_row_q : s1_row_q;
      s1_col_d    = produce ? out_col_q : s1_col_q;
   end

   // Read on accept, write back one cycle later: the next read always targets
   // a different column, so there is no read/write collision.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_rd_q <= line_mem[in_col_q];
      end
      if (s1_fetch_q) begin
         line_mem[s1_addr_q] <= {mem_rd_q[7:0], s1_pix_q};
      end
   end

   // ---------------------------------------------------------------------
   // stage 2: window shift; row-wrap garbage only reaches border centres
   // ---------------------------------------------------------------------
   always_comb begin
      col0_t_d = col0_t_q;
      col0_m_d = col0_m_q;
      col0_b_d = col0_b_q;
      col1_t_d = col1_t_q;
      col1_m_d = col1_m_q;
      col1_b_d = col1_b_q;
      col2_m_d = col2_m_q;
      s2_border_d = s2_border_q;
      s2_row_d    = s2_row_q;
      s2_col_d    = s2_col_q;
      s2_valid_d  = s1_valid_q;
      if (s1_valid_q) begin
         col0_t_d = mem_rd_q[15:8];
         col0_m_d = mem_rd_q[7:0];
         col0_b_d = s1_pix_q;
         col1_t_d = col0_t_q;
         col1_m_d = col0_m_q;
         col1_b_d = col0_b_q;
         col2_m_d = col1_m_q;
         s2_border_d = s1_border_q;
         s2_row_d    = s1_row_q;
         s2_col_d    = s1_col_q;
      end
   end

   // ---------------------------------------------------------------------
   // kernel and output stage
   // ---------------------------------------------------------------------
   always_comb begin
      sum = $signed({3'b000, col1_t_q}) + $signed({3'b000, col1_b_q}) +
            $signed({3'b000, col2_m_q}) + $signed({3'b000, col0_m_q}) -
            $signed({1'b0, col1_m_q, 2'b00});
      mag = sum[10] ? 11'(-sum) : 11'(sum);
      sat = (mag[10:8] != 3'b000) ? 8'hFF : mag[7:0];
   end

   always_comb begin
      lap_valid_d = s2_valid_q;
      lap_out_d   = lap_out_q;
      lap_row_d   = lap_row_q;
      lap_col_d   = lap_col_q;
      if (s2_valid_q) begin
         lap_out_d = s2_border_q ? 8'h00 : sat;
         lap_row_d = s2_row_q;
         lap_col_d = s2_col_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
         in_row_q    <= '0;
         in_col_q    <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         s1_valid_q  <= 1'b0;
         s1_fetch_q  <= 1'b0;
         s1_pix_q    <= '0;
         s1_addr_q   <= '0;
         s1_border_q <= 1'b0;
         s1_row_q    <= '0;
         s1_col_q    <= '0;
         col0_t_q    <= '0;
         col0_m_q    <= '0;
         col0_b_q    <= '0;
         col1_t_q    <= '0;
         col1_m_q    <= '0;
         col1_b_q    <= '0;
         col2_m_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_border_q <= 1'b0;
         s2_row_q    <= '0;
         s2_col_q    <= '0;
         lap_valid_q <= 1'b0;
         lap_out_q   <= '0;
         lap_row_q   <= '0;
         lap_col_q   <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         in_row_q    <= in_row_d;
         in_col_q    <= in_col_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         s1_valid_q  <= s1_valid_d;
         s1_fetch_q  <= s1_fetch_d;
         s1_pix_q    <= s1_pix_d;
         s1_addr_q   <= s1_addr_d;
         s1_border_q <= s1_border_d;
         s1_row_q    <= s1_row_d;
         s1_col_q    <= s1_col_d;
         col0_t_q    <= col0_t_d;
         col0_m_q    <= col0_m_d;
         col0_b_q    <= col0_b_d;
         col1_t_q    <= col1_t_d;
         col1_m_q    <= col1_m_d;
         col1_b_q    <= col1_b_d;
         col2_m_q    <= col2_m_d;
         s2_valid_q  <= s2_valid_d;
         s2_border_q <= s2_border_d;
         s2_row_q    <= s2_row_d;
         s2_col_q    <= s2_col_d;
         lap_valid_q <= lap_valid_d;
         lap_out_q   <= lap_out_d;
         lap_row_q   <= lap_row_d;
         lap_col_q   <= lap_col_d;
      end
   end

   assign lap_valid     = lap_valid_q;
   assign lap_out       = lap_out_q;
   assign center_row_s1 = 32'(lap_row_q);
   assign center_col_s1 = 32'(lap_col_q);

endmodule

// File: tb/tb_laplacian_3x3.sv
`timescale 1ns/1ps
// Directed bench for laplacian_3x3 on a small 8x8 frame.
module tb_laplacian_3x3;

   localparam int W = 8;
   localparam int H = 8;
   localparam int N = W * H;
   localparam int CAP = 160;

   logic        clk;
   logic        rst;
   logic        gray_valid;
   logic [7:0]  gray;
   logic        lap_valid;
   logic [7:0]  lap_out;
   logic [31:0] center_row_s1;
   logic [31:0] center_col_s1;

   laplacian_3x3 #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
      .clk           (clk),
      .rst           (rst),
      .gray_valid    (gray_valid),
      .gray          (gray),
      .lap_valid     (lap_valid),
      .lap_out       (lap_out),
      .center_row_s1 (center_row_s1),
      .center_col_s1 (center_col_s1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_out = 0;
   int lat_acc = 0;
   int img     [H][W];
   int got_val [CAP];
   int got_row [CAP];
   int got_col [CAP];
   int got_cyc [CAP];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (lap_valid) begin
         if (n_out < CAP) begin
            got_val[n_out] = int'(lap_out);
            got_row[n_out] = int'(center_row_s1);
            got_col[n_out] = int'(center_col_s1);
            got_cyc[n_out] = cyc;
         end
         n_out = n_out + 1;
      end
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model(input int r, input int c);
      int s;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
      s = img[r-1][c] + img[r+1][c] + img[r][c-1] + img[r][c+1] - 4*img[r][c];
      if (s < 0) s = -s;
      return (s > 255) ? 255 : s;
   endfunction

   task automatic fill(input int v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = v;
   endtask

   // drive npx pixels of img with 'gap' idle cycles after each
   task automatic drive(input int npx, input int gap);
      for (int p = 0; p < npx; p++) begin
         @(negedge clk);
         gray_valid = 1'b1;
         gray       = 8'(img[p / W][p % W]);
         if (p == W + 1) lat_acc = cyc + 1;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            gray_valid = 1'b0;
         end
      end
      @(negedge clk);
      gray_valid = 1'b0;
   endtask

   task automatic run_frame(input string name, input int gap);
      int budget;
      n_out = 0;
      drive(N, gap);
      budget = 0;
      while (n_out < N && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      repeat (6) @(negedge clk);
      chk($sformatf("%s_count", name), n_out, N);
      if (n_out >= N) begin
         chk($sformatf("%s_latency", name), got_cyc[0], lat_acc + 2);
         for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_row[%0d]", name, k), got_row[k], k / W);
            chk($sformatf("%s_col[%0d]", name, k), got_col[k], k % W);
            chk($sformatf("%s_val[%0d]", name, k), got_val[k], model(k / W, k % W));
         end
         // last pixel's own result, then W+1 flush results back to back
         for (int k = N - W - 1; k < N; k++)
            chk($sformatf("%s_flush_cyc[%0d]", name, k), got_cyc[k], got_cyc[k-1] + 1);
      end
   endtask

   initial begin
      rst        = 1'b0;
      gray_valid = 1'b0;
      gray       = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_valid", lap_valid, 0);
      chk("rst_out",   lap_out, 0);
      chk("rst_row",   center_row_s1, 0);
      chk("rst_col",   center_col_s1, 0);
      rst = 1'b1;
      @(negedge clk);

      // flat frame, back to back; first result (0,0) two cycles after pixel W+1
      fill(100);
      run_frame("flat", 0);
      if (n_out >= N) begin
         chk("flat_first_row", got_row[0], 0);
         chk("flat_first_val", got_val[0], 0);
      end

      // single bright pixel, saturating centre
      fill(0);
      img[5][5] = 200;
      run_frame("spot", 0);
      if (n_out >= N) begin
         chk("spot_c",  got_val[5*W+5], 255);
         chk("spot_n",  got_val[4*W+5], 200);
         chk("spot_s",  got_val[6*W+5], 200);
         chk("spot_w",  got_val[5*W+4], 200);
         chk("spot_e",  got_val[5*W+6], 200);
         chk("spot_dg", got_val[4*W+4], 0);
      end

      // centre 10 with four neighbours 20, one pixel every 4 cycles
      fill(0);
      img[5][5] = 10;
      img[4][5] = 20;
      img[6][5] = 20;
      img[5][4] = 20;
      img[5][6] = 20;
      run_frame("plus", 3);
      if (n_out >= N) begin
         chk("plus_c",  got_val[5*W+5], 40);  // 4*20 - 4*10
         chk("plus_n",  got_val[4*W+5], 70);  // |10 - 4*20|
         chk("plus_dg", got_val[4*W+4], 40);  // 20 + 20 - 0
      end

      // mid-frame reset, then a clean frame
      fill(60);
      img[3][3] = 7;
      n_out = 0;
      drive(20, 0);
      chk("pre_rst_valid", lap_valid, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", lap_valid, 0);
      @(negedge clk);
      chk("mid_rst_valid_next", lap_valid, 0);
      rst = 1'b1;
      @(negedge clk);
      run_frame("after_rst", 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
